pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_TIMEOUT, default 255, meaning max MC_WAIT cycles before timeout.
REQ-002 SHALL have parameter STALL_CNT_W, default 16, meaning stall counter width.
REQ-003 SHALL use one clock and an asynchronous active-low reset, named as below.
REQ-004 SHALL have these ports:
- clk  in  1  rising-edge clock
- rst  in  1  async active-low reset
- RegRs_ID  in  5  ID source register rs
- RegRt_ID  in  5  ID source register rt
- use_rt_ID  in  1  ID instruction reads rt
- MemRead_EX  in  1  EX instruction is a load
- RegWrite_EX  in  1  EX instruction writes a register
- DestReg_EX  in  5  EX destination register (post RegDst/jal mux)
- branch_taken_ID  in  1  ID resolved taken branch or jump
- mc_start_EX  in  1  EX launches multi-cycle unit (AES core)
- mc_done  in  1  multi-cycle unit result valid
- err_clr  in  1  clears mc_timeout
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID zeroing
- id_ex_bubble  out  1  ID/EX loads zeros (NOP)
- id_ex_hold  out  1  ID/EX keeps contents
- mc_timeout  out  1  sticky watchdog flag
- stall_cycles  out  STALL_CNT_W  saturating stall count

Function
REQ-005 SHALL implement FSM states RUN, MC_WAIT, MC_ERR.
REQ-006 SHALL detect load-use combinationally when all hold: MemRead_EX=1, RegWrite_EX=1, DestReg_EX!=0, and DestReg_EX==RegRs_ID or (use_rt_ID=1 and DestReg_EX==RegRt_ID).
REQ-007 In RUN with load-use: SHALL drive pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0 in the same cycle; the state stays RUN.
REQ-008 In RUN with branch_taken_ID and no load-use: SHALL drive if_id_flush=1, pc_write=1, if_id_write=1.
REQ-009 When load-use and branch_taken_ID coincide, the stall SHALL win and the flush SHALL be suppressed that cycle.
REQ-010 In RUN with mc_start_EX=1: SHALL move to MC_WAIT next edge. That cycle's outputs follow REQ-007/008 and are otherwise the default.
REQ-011 In MC_WAIT: SHALL drive pc_write=0, if_id_write=0, id_ex_hold=1, id_ex_bubble=0, if_id_flush=0, ignoring load-use and branch inputs.
REQ-012 In MC_WAIT: SHALL increment an 8-bit watchdog each cycle. The watchdog SHALL clear on entry to MC_WAIT.
REQ-013 In MC_WAIT with mc_done=1: SHALL return to RUN next edge, including on the cycle the watchdog equals MC_TIMEOUT (done wins).
REQ-014 In MC_WAIT with watchdog==MC_TIMEOUT and mc_done=0: SHALL go to MC_ERR.
REQ-015 In MC_ERR: SHALL set mc_timeout=1, drive default outputs, and return to RUN next edge.
REQ-016 mc_timeout SHALL stay 1 until err_clr=1. Set SHALL win over a simultaneous err_clr.
REQ-017 mc_done outside MC_WAIT SHALL be ignored.
REQ-018 Default outputs SHALL be pc_write=1, if_id_write=1, others 0.
REQ-019 stall_cycles SHALL increment on each edge where pc_write=0 and SHALL saturate at all-ones without wrap.

Reset
REQ-020 rst=0 SHALL asynchronously force state RUN, watchdog 0, mc_timeout 0, stall_cycles 0.
REQ-021 Reset mid-MC_WAIT SHALL abandon the wait, with no mc_timeout. After release, outputs SHALL follow RUN rules on the current inputs.

Structure
REQ-022 Package pipe_ctrl_pkg SHALL hold the state enum, MC_TIMEOUT and STALL_CNT_W defaults, and the register index width (5).
REQ-023 Load-use comparison SHALL be one sub-module, hazard_detect (purely combinational). FSM, watchdog and counter SHALL live in pipe_hazard_ctrl.

Verification
REQ-024 Load-use: MemRead_EX=1, RegWrite_EX=1, DestReg_EX=8, RegRs_ID=8 -> same cycle pc_write=0, id_ex_bubble=1; next cycle with MemRead_EX=0 -> defaults; stall_cycles=1.
REQ-025 Register zero: as REQ-024 but DestReg_EX=0, RegRs_ID=0 -> no stall. Also RegRt_ID=8 with use_rt_ID=0 -> no stall.
REQ-026 Conflict: load-use and branch_taken_ID together -> if_id_flush=0, stall asserted. Next cycle branch alone -> if_id_flush=1.
REQ-027 Multi-cycle: mc_start_EX pulse, mc_done after 5 cycles -> exactly 5 cycles of id_ex_hold=1 and pc_write=0, then RUN; stall_cycles=5.
REQ-028 Timeout: MC_TIMEOUT=4, no mc_done -> MC_ERR after 5 MC_WAIT cycles, mc_timeout=1 sticky until err_clr. mc_done on the watchdog=4 cycle -> RUN, no flag.
REQ-029 Reset and saturation: rst=0 asserted in MC_WAIT -> immediate RUN, counters 0. With STALL_CNT_W=4 and 20 stall cycles -> stall_cycles=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
// Holds the controller state encoding, the output bundle and register-index width.
package pipe_ctrl_pkg;

   localparam int REG_IDX_W       = 5;
   localparam int MC_TIMEOUT_DEF  = 255;
   localparam int STALL_CNT_W_DEF = 16;
   localparam int WDOG_W          = 8;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      MC_ERR  = 2'd2
   } ctrlState_t;

   typedef struct packed {
      logic pcWrite;
      logic ifIdWrite;
      logic ifIdFlush;
      logic idExBubble;
      logic idExHold;
   } ctrlOut_t;

   // Free-running pipeline: fetch advances, nothing is squashed or held.
   function automatic ctrlOut_t defaultOut();
      ctrlOut_t o;
      o.pcWrite    = 1'b1;
      o.ifIdWrite  = 1'b1;
      o.ifIdFlush  = 1'b0;
      o.idExBubble = 1'b0;
      o.idExHold   = 1'b0;
      return o;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use detector: an EX-stage load whose destination feeds
// an operand the ID-stage instruction actually reads.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_IDX_W-1:0] RegRs_ID,
   input  logic [REG_IDX_W-1:0] RegRt_ID,
   input  logic                 use_rt_ID,
   input  logic                 MemRead_EX,
   input  logic                 RegWrite_EX,
   input  logic [REG_IDX_W-1:0] DestReg_EX,
   output logic                 loadUse
);

   logic destLive;
   logic rsMatch;
   logic rtMatch;

   // Register zero is hard-wired, so a load targeting it never creates a dependency.
   assign destLive = MemRead_EX && RegWrite_EX && (DestReg_EX != '0);
   assign rsMatch  = (DestReg_EX == RegRs_ID);
   assign rtMatch  = use_rt_ID && (DestReg_EX == RegRt_ID);
   assign loadUse  = destLive && (rsMatch || rtMatch);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and a watchdog-guarded
// freeze while a multi-cycle unit (AES core) computes; counts stalled cycles.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT  = MC_TIMEOUT_DEF,
   parameter int STALL_CNT_W = STALL_CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [REG_IDX_W-1:0]   RegRs_ID,
   input  logic [REG_IDX_W-1:0]   RegRt_ID,
   input  logic                   use_rt_ID,
   input  logic                   MemRead_EX,
   input  logic                   RegWrite_EX,
   input  logic [REG_IDX_W-1:0]   DestReg_EX,
   input  logic                   branch_taken_ID,
   input  logic                   mc_start_EX,
   input  logic                   mc_done,
   input  logic                   err_clr,
   output logic                   pc_write,
   output logic                   if_id_write,
   output logic                   if_id_flush,
   output logic                   id_ex_bubble,
   output logic                   id_ex_hold,
   output logic                   mc_timeout,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [WDOG_W-1:0] TIMEOUT_VAL = WDOG_W'(MC_TIMEOUT);

   ctrlState_t        state;
   logic [WDOG_W-1:0] watchdog;
   logic              loadUse;
   logic              wdExpired;
   logic              enterErr;
   ctrlOut_t          ctrl;

   hazard_detect uHazard (
      .RegRs_ID    (RegRs_ID),
      .RegRt_ID    (RegRt_ID),
      .use_rt_ID   (use_rt_ID),
      .MemRead_EX  (MemRead_EX),
      .RegWrite_EX (RegWrite_EX),
      .DestReg_EX  (DestReg_EX),
      .loadUse     (loadUse)
   );

   assign wdExpired = (watchdog == TIMEOUT_VAL);
   assign enterErr  = (state == MC_WAIT) && !mc_done && wdExpired;

   // Outputs react in the same cycle as the hazard, so they decode the
   // registered state together with the live ID/EX inputs.
   always_comb begin
      // NOTE: assign every field a default first so no path leaves ctrl unassigned (no latch).
      ctrl = defaultOut();
      unique case (state)
         RUN: begin
            if (loadUse) begin
               ctrl.pcWrite    = 1'b0;
               ctrl.ifIdWrite  = 1'b0;
               ctrl.idExBubble = 1'b1;
            end else if (branch_taken_ID) begin
               ctrl.ifIdFlush  = 1'b1;
            end
         end
         MC_WAIT: begin
            ctrl.pcWrite   = 1'b0;
            ctrl.ifIdWrite = 1'b0;
            ctrl.idExHold  = 1'b1;
         end
         MC_ERR: ctrl = defaultOut();
         default: ctrl = defaultOut();
      endcase
   end

   assign pc_write     = ctrl.pcWrite;
   assign if_id_write  = ctrl.ifIdWrite;
   assign if_id_flush  = ctrl.ifIdFlush;
   assign id_ex_bubble = ctrl.idExBubble;
   assign id_ex_hold   = ctrl.idExHold;

   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst) begin
         state    <= RUN;
         watchdog <= '0;
      end else begin
         unique case (state)
            RUN: begin
               if (mc_start_EX) begin
                  state    <= MC_WAIT;
                  watchdog <= '0;
               end
            end
            MC_WAIT: begin
               watchdog <= watchdog + 1'b1;
               if (mc_done) begin
                  state <= RUN;
               end else if (wdExpired) begin
                  state <= MC_ERR;
               end
            end
            MC_ERR:  state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Flag is raised on the edge into MC_ERR and held through it, so a clear
   // arriving on either of those cycles loses to the set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mc_timeout <= 1'b0;
      end else if (enterErr || (state == MC_ERR)) begin
         mc_timeout <= 1'b1;
      end else if (err_clr) begin
         mc_timeout <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
      end else if (!ctrl.pcWrite && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a behavioural reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_pipe_hazard_ctrl;

   localparam int TO  = 4;
   localparam int SW  = 4;
   localparam int SAT = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    RegRs_ID = '0, RegRt_ID = '0, DestReg_EX = '0;
   logic          use_rt_ID = 0, MemRead_EX = 0, RegWrite_EX = 0, branch_taken_ID = 0;
   logic          mc_start_EX = 0, mc_done = 0, err_clr = 0;
   logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, mc_timeout;
   logic [SW-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MC_TIMEOUT(TO), .STALL_CNT_W(SW)) dut (
      .clk(clk), .rst(rst),
      .RegRs_ID(RegRs_ID), .RegRt_ID(RegRt_ID), .use_rt_ID(use_rt_ID),
      .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX), .DestReg_EX(DestReg_EX),
      .branch_taken_ID(branch_taken_ID), .mc_start_EX(mc_start_EX),
      .mc_done(mc_done), .err_clr(err_clr),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
      .mc_timeout(mc_timeout), .stall_cycles(stall_cycles)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: waitIdx counts cycles spent waiting (-1 when not waiting).
   int waitIdx = -1;
   bit inErr   = 0;
   bit flagM   = 0;
   int stallM  = 0;

   function automatic bit mLoadUse();
      return MemRead_EX && RegWrite_EX && (DestReg_EX != 0) &&
             ((DestReg_EX == RegRs_ID) || (use_rt_ID && (DestReg_EX == RegRt_ID)));
   endfunction

   // {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold}
   function automatic logic [4:0] mOut();
      if (waitIdx >= 0)    return 5'b00001;
      if (inErr)           return 5'b11000;
      if (mLoadUse())      return 5'b00010;
      if (branch_taken_ID) return 5'b11100;
      return 5'b11000;
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         waitIdx = -1; inErr = 0; flagM = 0; stallM = 0;
      end else begin
         logic [4:0] e;
         bit toErr;
         e = mOut();
         if (!e[4] && stallM < SAT) stallM++;
         toErr = 0;
         if (waitIdx >= 0) begin
            if (mc_done) waitIdx = -1;
            else if (waitIdx == TO) begin waitIdx = -1; toErr = 1; end
            else waitIdx++;
         end else if (inErr) begin
            // leaves error state after one cycle
         end else if (mc_start_EX) begin
            waitIdx = 0;
         end
         if (toErr || inErr) flagM = 1;
         else if (err_clr)   flagM = 0;
         inErr = toErr;
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         logic [4:0] e;
         e = mOut();
         check("m_pc_write", pc_write, e[4]);
         check("m_if_id_write", if_id_write, e[3]);
         check("m_if_id_flush", if_id_flush, e[2]);
         check("m_id_ex_bubble", id_ex_bubble, e[1]);
         check("m_id_ex_hold", id_ex_hold, e[0]);
         check("m_mc_timeout", mc_timeout, flagM);
         check("m_stall_cycles", stall_cycles, stallM);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      RegRs_ID = 0; RegRt_ID = 0; DestReg_EX = 0; use_rt_ID = 0;
      MemRead_EX = 0; RegWrite_EX = 0; branch_taken_ID = 0;
      mc_start_EX = 0; mc_done = 0; err_clr = 0;
   endtask

   task automatic loadUse8();
      MemRead_EX = 1; RegWrite_EX = 1; DestReg_EX = 8; RegRs_ID = 8;
   endtask

   initial begin
      #1 rst = 0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_stall", stall_cycles, 0);
      check("reset_timeout", mc_timeout, 0);
      check("reset_pc_write", pc_write, 1);
      rst = 1;
      tick();

      // Load-use on rs
      loadUse8(); #1;
      check("lu_pc_write", pc_write, 0);
      check("lu_bubble", id_ex_bubble, 1);
      check("lu_if_id_write", if_id_write, 0);
      tick();
      MemRead_EX = 0; #1;
      check("lu_after_pc_write", pc_write, 1);
      check("lu_after_bubble", id_ex_bubble, 0);
      check("lu_after_stall", stall_cycles, 1);
      tick();

      // Register zero and unused rt
      MemRead_EX = 1; DestReg_EX = 0; RegRs_ID = 0; #1;
      check("r0_pc_write", pc_write, 1);
      tick();
      DestReg_EX = 8; RegRs_ID = 3; RegRt_ID = 8; use_rt_ID = 0; #1;
      check("rt_unused_pc_write", pc_write, 1);
      tick();
      use_rt_ID = 1; #1;
      check("rt_used_pc_write", pc_write, 0);
      tick();

      // Load-use coincident with branch: stall wins
      branch_taken_ID = 1; #1;
      check("conf_flush", if_id_flush, 0);
      check("conf_pc_write", pc_write, 0);
      check("conf_bubble", id_ex_bubble, 1);
      tick();
      idle(); branch_taken_ID = 1; #1;
      check("br_flush", if_id_flush, 1);
      check("br_pc_write", pc_write, 1);
      check("br_stall", stall_cycles, 3);
      tick();
      idle();

      // Multi-cycle op, done on 5th wait cycle; hazards ignored while waiting
      mc_start_EX = 1; #1;
      check("mc_start_pc_write", pc_write, 1);
      tick();
      idle();
      for (int i = 1; i <= 5; i++) begin
         if (i == 2) branch_taken_ID = 1;
         if (i == 3) loadUse8();
         mc_done = (i == 5);
         #1;
         check("mc_wait_hold", id_ex_hold, 1);
         check("mc_wait_pc_write", pc_write, 0);
         check("mc_wait_flush", if_id_flush, 0);
         check("mc_wait_bubble", id_ex_bubble, 0);
         tick();
         idle();
      end
      #1;
      check("mc_exit_hold", id_ex_hold, 0);
      check("mc_exit_pc_write", pc_write, 1);
      check("mc_exit_stall", stall_cycles, 8);
      tick();

      // mc_done outside MC_WAIT has no effect
      mc_done = 1; #1;
      check("stray_done_hold", id_ex_hold, 0);
      tick();
      mc_done = 0; #1;
      check("stray_done_hold2", id_ex_hold, 0);
      tick();

      // Watchdog timeout; err_clr on the set cycles loses
      mc_start_EX = 1; tick(); mc_start_EX = 0;
      for (int i = 1; i <= 5; i++) begin
         err_clr = (i == 5); #1;
         check("to_wait_hold", id_ex_hold, 1);
         tick();
      end
      #1;
      check("err_pc_write", pc_write, 1);
      check("err_hold", id_ex_hold, 0);
      check("err_flag", mc_timeout, 1);
      tick();
      err_clr = 0; #1;
      check("flag_after_err", mc_timeout, 1);
      check("to_stall", stall_cycles, 13);
      tick(); tick();
      check("flag_sticky", mc_timeout, 1);
      err_clr = 1; tick(); err_clr = 0; #1;
      check("flag_cleared", mc_timeout, 0);

      // Done exactly when watchdog reaches MC_TIMEOUT
      mc_start_EX = 1; tick(); mc_start_EX = 0;
      for (int i = 1; i <= 5; i++) begin
         mc_done = (i == 5); #1;
         check("edge_wait_hold", id_ex_hold, 1);
         tick();
      end
      mc_done = 0; #1;
      check("edge_exit_hold", id_ex_hold, 0);
      check("edge_no_flag", mc_timeout, 0);
      check("edge_stall_sat", stall_cycles, SAT);
      tick();

      // Asynchronous reset in the middle of a wait
      mc_start_EX = 1; tick(); mc_start_EX = 0; tick();
      check("pre_rst_hold", id_ex_hold, 1);
      #2 rst = 0; #1;
      check("rst_hold", id_ex_hold, 0);
      check("rst_pc_write", pc_write, 1);
      check("rst_stall", stall_cycles, 0);
      check("rst_flag", mc_timeout, 0);
      loadUse8();
      tick();
      rst = 1; #1;
      check("post_rst_pc_write", pc_write, 0);
      check("post_rst_bubble", id_ex_bubble, 1);
      check("post_rst_hold", id_ex_hold, 0);

      // 20 consecutive stall cycles saturate the 4-bit counter
      repeat (20) tick();
      check("sat_stall", stall_cycles, 15);
      idle(); tick(); #1;
      check("sat_hold_stall", stall_cycles, 15);
      check("sat_pc_write", pc_write, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
